// File: rtl/spi_master_pkg.sv
// spi_master_pkg: definitions shared by the SPI master transmit and receive shifters
package spi_master_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int TRGT_RST = 8;
  typedef enum logic [1:0] {IDLE, TRANSMIT, WAIT_FIFO} tx_state_e;
endpackage

// File: rtl/spi_master_tx.sv
// spi_master_tx: pops FIFO words and shifts them MSB-first onto sdo0..3 in standard or quad mode
module spi_master_tx
  import spi_master_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  tx_edge,
  output logic                  tx_done,
  output logic                  sdo0,
  output logic                  sdo1,
  output logic                  sdo2,
  output logic                  sdo3,
  input  logic                  en_quad_in,
  input  logic [CNT_WIDTH-1:0]  counter_in,
  input  logic                  counter_in_upd,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  clk_en_o
);
  tx_state_e state, state_n;
  logic [CNT_WIDTH-1:0] counter, counter_n, counter_trgt;
  logic [WORD_WIDTH-1:0] data_int, data_int_n, data_sh;
  logic done, word_done;
  assign data_sh = en_quad_in ? {data_int[WORD_WIDTH-5:0], 4'b0} : {data_int[WORD_WIDTH-2:0], 1'b0};
  assign word_done = en_quad_in ? &counter[2:0] : &counter[4:0];
  // a zero target never completes rather than wrapping around to all-ones
  assign done = state == TRANSMIT && tx_edge && counter_trgt != '0 &&
                counter == counter_trgt - CNT_WIDTH'(1);
  assign tx_done = done;
  assign sdo0 = en_quad_in ? data_int[WORD_WIDTH-4] : data_int[WORD_WIDTH-1];
  assign sdo1 = en_quad_in & data_int[WORD_WIDTH-3];
  assign sdo2 = en_quad_in & data_int[WORD_WIDTH-2];
  assign sdo3 = en_quad_in & data_int[WORD_WIDTH-1];
  always_comb begin
    state_n = state;
    counter_n = counter;
    data_int_n = data_int;
    data_ready = 1'b0;
    clk_en_o = 1'b0;
    case (state)
      IDLE: if (en && data_valid) begin
        data_int_n = data;
        data_ready = 1'b1;
        counter_n = '0;
        state_n = TRANSMIT;
      end
      TRANSMIT: begin
        clk_en_o = 1'b1;
        if (tx_edge) begin
          counter_n = counter + CNT_WIDTH'(1);
          data_int_n = data_sh;
          if (done) begin
            counter_n = '0;
            state_n = IDLE;
          end else if (word_done && data_valid) begin
            data_int_n = data;
            data_ready = 1'b1;
          end else if (word_done) begin
            clk_en_o = 1'b0;
            state_n = WAIT_FIFO;
          end
        end
      end
      WAIT_FIFO: if (data_valid) begin
        data_int_n = data;
        data_ready = 1'b1;
        state_n = TRANSMIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      counter <= '0;
      data_int <= '0;
    end else begin
      state <= state_n;
      counter <= counter_n;
      data_int <= data_int_n;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) counter_trgt <= CNT_WIDTH'(TRGT_RST);
    else if (counter_in_upd) counter_trgt <= en_quad_in ? counter_in >> 2 : counter_in;
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: randomized bench checking spi_master_tx against a bit-stream model of the transfer
module tb_spi_master_tx;
  localparam int CW = 16;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, tx_edge = 1'b0, en_quad_in = 1'b0;
  logic counter_in_upd = 1'b0, data_valid = 1'b0;
  logic [CW-1:0] counter_in = '0;
  logic [31:0] data = '0;
  logic tx_done, sdo0, sdo1, sdo2, sdo3, data_ready, clk_en_o;

  spi_master_tx #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .tx_edge(tx_edge), .tx_done(tx_done),
    .sdo0(sdo0), .sdo1(sdo1), .sdo2(sdo2), .sdo3(sdo3),
    .en_quad_in(en_quad_in), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ready(data_ready), .clk_en_o(clk_en_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit busy, waiting, start_req, starve, gated, chk_on;
  bit edge_act, last, bnd, exp_dr, exp_ce, exp_done;
  logic [3:0] exp_sdo;
  int k, nsym, trgt = 8, wcnt, wtot, pops, done_edge, pop_edge;
  logic [31:0] fq[$];
  logic [31:0] xw[$];
  logic [63:0] cap;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // symbol idx of the transfer's bit stream: words concatenated MSB-first
  function automatic logic [3:0] sym(int idx);
    int spw;
    int p;
    logic [31:0] w;
    spw = en_quad_in ? 8 : 32;
    if (idx / spw >= xw.size()) return 4'hx;
    w = xw[idx / spw];
    p = idx % spw;
    return en_quad_in ? w[31-4*p -: 4] : {3'b0, w[31-p]};
  endfunction

  always @(negedge clk) begin
    #2;
    if (chk_on && rstn) begin
      check("data_ready", 64'(data_ready), 64'(exp_dr));
      check("clk_en_o", 64'(clk_en_o), 64'(exp_ce));
      check("tx_done", 64'(tx_done), 64'(exp_done));
      if (busy && !waiting) check("sdo", 64'({sdo3, sdo2, sdo1, sdo0}), 64'(exp_sdo));
      if (edge_act) cap = en_quad_in ? {cap[59:0], sdo3, sdo2, sdo1, sdo0} : {cap[62:0], sdo0};
      if (tx_done) done_edge = k + 1;
      if (data_ready) begin
        pops++;
        pop_edge = k + (edge_act ? 1 : 0);
      end
    end
  end

  task automatic tick();
    int spw;
    @(negedge clk);
    spw = en_quad_in ? 8 : 32;
    data_valid = fq.size() > 0 && (!gated || $urandom_range(0, 3) != 0) &&
                 (!starve || !busy || (waiting && wcnt >= 20));
    data = fq.size() > 0 ? fq[0] : $urandom;
    tx_edge = 1'($urandom_range(0, 1));
    en = busy ? 1'($urandom_range(0, 1)) : start_req;
    edge_act = busy && !waiting && tx_edge;
    last = edge_act && k == nsym - 1;
    bnd = edge_act && !last && (k + 1) % spw == 0;
    exp_dr = (!busy && en && data_valid) || (bnd && data_valid) || (waiting && data_valid);
    exp_ce = busy && !waiting && !(bnd && !data_valid);
    exp_done = last;
    exp_sdo = busy && !waiting ? sym(k) : 4'h0;
    chk_on = 1'b1;
    @(posedge clk);
    if (!busy && en && data_valid) begin
      busy = 1'b1;
      k = 0;
      nsym = trgt;
      xw.delete();
      start_req = 1'b0;
    end
    if (exp_dr) xw.push_back(fq.pop_front());
    if (waiting) begin
      wcnt++;
      wtot++;
      if (data_valid) waiting = 1'b0;
    end else if (edge_act) begin
      k++;
      if (last) busy = 1'b0;
      else if (bnd && !data_valid) begin
        waiting = 1'b1;
        wcnt = 0;
      end
    end
    if (counter_in_upd) trgt = en_quad_in ? int'(counter_in >> 2) : int'(counter_in);
    #1 chk_on = 1'b0;
  endtask

  task automatic run(bit q, int len, bit upd);
    en_quad_in = q;
    if (upd) begin
      counter_in = CW'(len);
      counter_in_upd = 1'b1;
      tick();
      counter_in_upd = 1'b0;
    end
    start_req = 1'b1;
    cap = '0;
    pops = 0;
    done_edge = 0;
    pop_edge = 0;
    wtot = 0;
    for (int i = 0; i < 3000 && (start_req || busy); i++) tick();
    if (start_req || busy) check("timeout", 64'(1), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", 64'({sdo3, sdo2, sdo1, sdo0, tx_done, data_ready, clk_en_o}), 64'(0));
    @(negedge clk) rstn = 1'b1;

    fq = '{32'hA5A50F0F};
    run(1'b0, 32, 1'b1);
    check("std32_stream", cap & 64'hFFFF_FFFF, 64'hA5A50F0F);
    check("std32_done_edge", 64'(done_edge), 64'(32));
    check("std32_pops", 64'(pops), 64'(1));
    repeat (3) tick();

    fq = '{32'h12345678, 32'h9ABCDEF0};
    run(1'b1, 64, 1'b1);
    check("quad_stream", cap, 64'h123456789ABCDEF0);
    check("quad_done_edge", 64'(done_edge), 64'(16));
    check("quad_pop_edge", 64'(pop_edge), 64'(8));
    check("quad_pops", 64'(pops), 64'(2));

    starve = 1'b1;
    fq = '{32'hDEADBEEF, 32'h0F1E2D3C};
    run(1'b0, 64, 1'b1);
    starve = 1'b0;
    check("under_stream", cap, 64'hDEADBEEF0F1E2D3C);
    check("under_done_edge", 64'(done_edge), 64'(64));
    check("under_wait_cycles", 64'(wtot), 64'(21));

    fq = '{32'hC3000000, 32'h11111111};
    run(1'b0, 8, 1'b1);
    check("short_stream", cap & 64'hFF, 64'hC3);
    check("short_done_edge", 64'(done_edge), 64'(8));
    repeat (4) tick();
    check("short_no_second_pop", 64'(pops), 64'(1));
    check("short_fifo_left", 64'(fq.size()), 64'(1));
    fq.delete();

    start_req = 1'b1;
    pops = 0;
    repeat (10) tick();
    check("empty_no_pop", 64'(pops), 64'(0));
    fq = '{32'h80000001};
    run(1'b0, 8, 1'b0);
    check("empty_then_stream", cap & 64'hFF, 64'h80);

    fq = '{32'hF0F0AAAA};
    en_quad_in = 1'b0;
    counter_in = CW'(32);
    counter_in_upd = 1'b1;
    tick();
    counter_in_upd = 1'b0;
    start_req = 1'b1;
    for (int i = 0; i < 500 && (start_req || k < 10); i++) tick();
    @(negedge clk);
    rstn = 1'b0;
    tx_edge = 1'b0;
    en = 1'b0;
    data_valid = 1'b0;
    #1 check("midreset_outputs", 64'({sdo3, sdo2, sdo1, sdo0, tx_done, data_ready, clk_en_o}), 64'(0));
    busy = 1'b0;
    waiting = 1'b0;
    start_req = 1'b0;
    trgt = 8;
    fq.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    fq = '{32'h5A000000};
    pops = 0;
    repeat (3) tick();
    check("post_reset_no_pop", 64'(pops), 64'(0));
    run(1'b0, 8, 1'b0);
    check("post_reset_stream", cap & 64'hFF, 64'h5A);
    check("post_reset_done_edge", 64'(done_edge), 64'(8));

    gated = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bit q;
      int n, spw;
      q = 1'($urandom_range(0, 1));
      spw = q ? 8 : 32;
      n = $urandom_range(1, 3 * spw);
      fq.delete();
      for (int w = 0; w < (n + spw - 1) / spw; w++) fq.push_back($urandom);
      run(q, q ? 4 * n + $urandom_range(0, 3) : n, 1'b1);
      check("rand_done_edge", 64'(done_edge), 64'(n));
    end
    gated = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
